// File: rtl/adder_share_pkg.sv
// adder_share_pkg
// Shared types and widths for the shared-adder scheduler.
//   OPW     : operand width of the shared adder
//   SUMW    : sum width of the shared adder (sign-extended operands, no overflow)
//   RETRY_W : width of the per-transaction retry counter
//   state_t : scheduler FSM states
package adder_share_pkg;

  localparam int OPW     = 8;
  localparam int SUMW    = 9;
  localparam int RETRY_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/adder_share_sched_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. The search starts one position after
// ptr and wraps modulo N, so the requester served last has lowest priority.
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  index of the most recently granted requester
//   grant out N   one-hot grant (zero when no request)
//   idx   out IW  encoded index of the grant
//   any   out 1   at least one request present
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int          pos;
  logic [IW-1:0] pos_idx;

  always_comb begin
    grant   = '0;
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    // Walk N positions starting at ptr+1; the first hit wins.
    for (int k = 1; k <= N; k++) begin
      pos     = (int'(ptr) + k) % N;
      pos_idx = IW'(pos);
      if (!any && req[pos_idx]) begin
        any            = 1'b1;
        grant[pos_idx] = 1'b1;
        idx            = pos_idx;
      end
    end
  end

endmodule

// File: rtl/adder_share_sched.sv
// adder_share_sched
// Time-multiplexes one external 8-bit signed adder among N_REQ requesters
// with round-robin arbitration. Every operation runs twice, the second pass
// with operands swapped; the two sums must agree. On disagreement the pair
// of passes is repeated up to MAX_RETRY times before the response is
// flagged with rsp_err.
//
// Handshakes (request side and response side) are valid/ready: a transfer
// happens on a rising edge where both valid and ready are high. Valid is
// never a function of ready. req_ready is one-hot or zero and is only
// raised in IDLE; rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_valid/ready    per-requester request handshake
//   req_a, req_b       packed signed operands, slice i = requester i
//   add_a, add_b       registered operands driven to the shared adder
//   add_sum            combinational sum returned by the shared adder
//   rsp_valid/ready    response handshake
//   rsp_id             requester index served
//   rsp_sum            pass-1 sum
//   rsp_err            retries exhausted, sum unreliable
//   rsp_retries        retries consumed by this transaction
//   fault_cnt          saturating count of pass mismatches
import adder_share_pkg::*;

module adder_share_sched #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [OPW*N_REQ-1:0]   req_a,
  input  logic [OPW*N_REQ-1:0]   req_b,
  output logic [OPW-1:0]         add_a,
  output logic [OPW-1:0]         add_b,
  input  logic [SUMW-1:0]        add_sum,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [SUMW-1:0]        rsp_sum,
  output logic                   rsp_err,
  output logic [RETRY_W-1:0]     rsp_retries,
  output logic [CNT_W-1:0]       fault_cnt
);

  // FSM state, kept as a named signal so checkers can bind to it.
  state_t             state;

  logic [ID_W-1:0]    rr_ptr;
  logic [OPW-1:0]     op_a;
  logic [OPW-1:0]     op_b;
  logic [ID_W-1:0]    cur_id;
  logic [RETRY_W-1:0] retry;
  logic [SUMW-1:0]    s1;

  logic [N_REQ-1:0]   gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [OPW-1:0]     sel_a;
  logic [OPW-1:0]     sel_b;
  logic               pass_match;
  logic               retry_left;
  logic [CNT_W-1:0]   fault_cnt_inc;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Grant is only offered in IDLE; reset forces it low so every output
  // reads zero while reset is held.
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;

  assign sel_a = req_a[int'(gnt_idx)*OPW +: OPW];
  assign sel_b = req_b[int'(gnt_idx)*OPW +: OPW];

  // The pass-2 sample is compared directly off add_sum in EXEC2; holding it
  // in a register first would only add a cycle.
  assign pass_match = (add_sum == s1);
  assign retry_left = (retry < RETRY_W'(MAX_RETRY));

  // Saturating increment: hold at all-ones.
  assign fault_cnt_inc = (fault_cnt == '1) ? fault_cnt : fault_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= ID_W'(N_REQ - 1);
      op_a        <= '0;
      op_b        <= '0;
      cur_id      <= '0;
      retry       <= '0;
      s1          <= '0;
      add_a       <= '0;
      add_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_sum     <= '0;
      rsp_err     <= 1'b0;
      rsp_retries <= '0;
      fault_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            cur_id <= gnt_idx;
            add_a  <= sel_a;
            add_b  <= sel_b;
            rr_ptr <= gnt_idx;
            retry  <= '0;
            state  <= EXEC1;
          end
        end

        EXEC1: begin
          s1    <= add_sum;
          // Second pass presents the operands swapped.
          add_a <= op_b;
          add_b <= op_a;
          state <= EXEC2;
        end

        EXEC2: begin
          if (pass_match) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= cur_id;
            rsp_sum     <= s1;
            rsp_err     <= 1'b0;
            rsp_retries <= retry;
            state       <= RESP;
          end else if (retry_left) begin
            fault_cnt <= fault_cnt_inc;
            retry     <= retry + 1'b1;
            add_a     <= op_a;
            add_b     <= op_b;
            state     <= EXEC1;
          end else begin
            fault_cnt   <= fault_cnt_inc;
            rsp_valid   <= 1'b1;
            rsp_id      <= cur_id;
            rsp_sum     <= s1;
            rsp_err     <= 1'b1;
            rsp_retries <= retry;
            state       <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_sched.sv
// tb_adder_share_sched
// Directed and randomized stimulus for adder_share_sched. The bench provides
// the shared adder (with an injectable one-bit corruption) and a reference
// model for grant order, sums, retry/err outcome, latency and fault count.
module tb_adder_share_sched;

  localparam int N         = 4;
  localparam int ID_W      = 2;
  localparam int MAX_RETRY = 2;
  localparam int CNT_W     = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [8*N-1:0]     req_a;
  logic [8*N-1:0]     req_b;
  logic [7:0]         add_a;
  logic [7:0]         add_b;
  logic [8:0]         add_sum;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [8:0]         rsp_sum;
  logic               rsp_err;
  logic [2:0]         rsp_retries;
  logic [CNT_W-1:0]   fault_cnt;
  logic               corrupt;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int m_ptr;
  int m_fault;

  always #5 clk = ~clk;

  // Bench-side shared adder; corrupt flips the LSB of the result.
  assign add_sum = ({add_a[7], add_a} + {add_b[7], add_b}) ^ {8'd0, corrupt};

  adder_share_sched #(
    .N_REQ     (N),
    .ID_W      (ID_W),
    .MAX_RETRY (MAX_RETRY),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_sum     (add_sum),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_sum     (rsp_sum),
    .rsp_err     (rsp_err),
    .rsp_retries (rsp_retries),
    .fault_cnt   (fault_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] mask, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"},   req_ready,   '0);
    check({tag, "_add_a"},       add_a,       '0);
    check({tag, "_add_b"},       add_b,       '0);
    check({tag, "_rsp_valid"},   rsp_valid,   '0);
    check({tag, "_rsp_id"},      rsp_id,      '0);
    check({tag, "_rsp_sum"},     rsp_sum,     '0);
    check({tag, "_rsp_err"},     rsp_err,     '0);
    check({tag, "_rsp_retries"}, rsp_retries, '0);
    check({tag, "_fault_cnt"},   fault_cnt,   '0);
  endtask

  // Runs one transaction starting just after a falling edge. n_bad is the
  // number of leading pass-2 samples the adder corrupts; delay is the number
  // of extra cycles rsp_ready stays low; abort_at > 0 pulses reset at that
  // cycle after the handshake instead of completing.
  task automatic txn(input logic [N-1:0] mask, input int n_bad, input int delay,
                     input int abort_at);
    int g, va, vb, exp_r, lat, seen, bad_seen;
    logic [8:0] exp_sum;
    logic [N-1:0] oh;
    logic exp_err;

    req_valid = mask;
    #1;
    g  = model_grant(mask, m_ptr);
    oh = '0;
    oh[g] = 1'b1;
    check("grant", req_ready, oh);
    va       = int'($signed(req_a[g*8 +: 8]));
    vb       = int'($signed(req_b[g*8 +: 8]));
    exp_sum  = 9'(va + vb);
    exp_r    = (n_bad < MAX_RETRY) ? n_bad : MAX_RETRY;
    exp_err  = (n_bad > MAX_RETRY);
    bad_seen = (n_bad < MAX_RETRY + 1) ? n_bad : MAX_RETRY + 1;
    lat      = 3 + 2 * exp_r;

    @(posedge clk);
    #1;
    m_ptr = g;
    // Operands must have been captured at the handshake.
    req_a = $urandom;
    req_b = $urandom;

    seen = -1;
    for (int c = 1; c <= lat + 4; c++) begin
      @(negedge clk);
      if (abort_at == c) begin
        rst = 1'b1;
        #1;
        check_zero("abort");
        req_valid = '0;
        corrupt   = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        m_ptr   = N - 1;
        m_fault = 0;
        return;
      end
      corrupt = (c % 2 == 0) && (c / 2 - 1 < n_bad);
      if (rsp_valid) begin
        seen = c;
        break;
      end
      check("busy_req_ready", req_ready, '0);
    end
    corrupt = 1'b0;
    check("latency", seen, lat);
    if (seen < 0) return;

    m_fault = m_fault + bad_seen;
    if (m_fault > (1 << CNT_W) - 1) m_fault = (1 << CNT_W) - 1;

    for (int d = 0; d <= delay; d++) begin
      check("rsp_valid",     rsp_valid,   1);
      check("rsp_id",        rsp_id,      g);
      check("rsp_sum",       rsp_sum,     exp_sum);
      check("rsp_err",       rsp_err,     exp_err);
      check("rsp_retries",   rsp_retries, exp_r);
      check("fault_cnt",     fault_cnt,   m_fault);
      check("resp_req_ready", req_ready,  '0);
      if (d < delay) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 0);
  endtask

  initial begin
    int r, nb;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    corrupt   = 1'b0;
    m_ptr     = N - 1;
    m_fault   = 0;

    // Reset values, with a request pending to show req_ready is held low.
    req_valid = 4'b1111;
    #12;
    check_zero("reset");
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Idle with no requests.
    repeat (3) begin
      @(negedge clk);
      check("idle_req_ready", req_ready, '0);
      check("idle_rsp_valid", rsp_valid, 0);
    end

    // Directed sums.
    set_ops(0, 8'd100, 8'd27);
    txn(4'b0001, 0, 0, 0);
    set_ops(2, 8'h80, 8'h80);
    txn(4'b0100, 0, 0, 0);
    set_ops(2, 8'd127, 8'hFF);
    txn(4'b0100, 0, 1, 0);

    // One corrupted pass-2 sample, then persistent corruption.
    set_ops(1, 8'd55, 8'hC3);
    txn(4'b0010, 1, 0, 0);
    set_ops(3, 8'hF0, 8'd9);
    txn(4'b1000, 3, 2, 0);

    // Fresh start: all requesters held valid, grant order 0,1,2,3,0.
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    m_ptr   = N - 1;
    m_fault = 0;
    req_a   = $urandom;
    req_b   = $urandom;
    txn(4'b1111, 0, 5, 0);
    txn(4'b1111, 0, 0, 0);
    txn(4'b1111, 1, 0, 0);
    txn(4'b1111, 0, 5, 0);
    txn(4'b1111, 0, 0, 0);

    // Reset during EXEC2, then the next grant starts from requester 0.
    txn(4'b1111, 0, 0, 2);
    req_a = $urandom;
    req_b = $urandom;
    txn(4'b1111, 0, 0, 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      req_a = $urandom;
      req_b = $urandom;
      r  = $urandom_range(0, 9);
      nb = (r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      txn(N'($urandom_range(1, 15)), nb, $urandom_range(0, 3), 0);
      req_valid = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
